mdpx_buf_reader: RTL and testbench
==================================

// Module: mdpx_buf_reader
// PURPOSE
//  Read-side engine for the 8-bit x 1024 dual-port frame buffer (mem_8b_1024) filled by the write engine.
//  On a start pulse it streams In_Length bytes from In_Base_Addr out of the RAM read port.
//  Output is a valid/ready byte stream with sync on the first byte and last on the final byte.
//  Hides RAM read latency with a credit-limited prefetch FIFO. Runs in the RAM read-clock domain.
// PARAMETERS
//  ADDR_W   10  RAM address width; buffer depth = 2**ADDR_W
//  DATA_W   8   byte width
//  RD_LAT   2   RAM read latency in cycles (addr registered + q registered); legal 1..3
// PORTS
//  In_Clk        in   1        RAM read clock; all logic on rising edge
//  In_Nreset     in   1        asynchronous, active-low reset
//  In_Start      in   1        1-cycle start pulse; ignored while Out_Busy=1
//  In_Base_Addr  in   ADDR_W   first RAM address; sampled on accepted start
//  In_Length     in   ADDR_W+1 byte count 0..2**ADDR_W; sampled on accepted start
//  Out_Rdaddr    out  ADDR_W   RAM read address
//  In_Rddata     in   DATA_W   RAM q, valid RD_LAT cycles after Out_Rdaddr
//  Out_Data      out  DATA_W   stream byte
//  Out_Valid     out  1        Out_Data valid
//  In_Ready      in   1        sink accepts when Out_Valid & In_Ready
//  Out_Sync      out  1        high with the first byte of a transfer
//  Out_Last      out  1        high with the final byte of a transfer
//  Out_Busy      out  1        transfer in progress
//  Out_Done      out  1        1-cycle pulse after the final byte is accepted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; issue/accept counters 0; in-flight pipe cleared.
//  FSM IDLE -> RUN on In_Start & In_Length!=0; IDLE -> DONE on In_Start & In_Length==0.
//  RUN: each cycle with issued<len and credit, drive Out_Rdaddr=base+issued (mod 2**ADDR_W), mark slot in-flight.
//  Credit: fifo_count + inflight_count < FIFO_DEPTH, FIFO_DEPTH = RD_LAT+2. Never overflows, never drops.
//  In-flight marker shift register of length RD_LAT; its tail pushes In_Rddata into the FIFO.
//  RUN -> DRAIN once issued==len; DRAIN -> DONE when the last byte is accepted (accepted==len).
//  DONE: Out_Done=1 for exactly 1 cycle; Out_Busy=0; next state IDLE. Start in DONE is ignored.
//  Out_Busy=1 in RUN and DRAIN, and in the start cycle's next cycle onward.
//  Out_Valid = FIFO non-empty (show-ahead); Out_Data = FIFO head. Pop on Out_Valid & In_Ready.
//  Out_Valid stays high and Out_Data stable while In_Ready=0 (no retraction).
//  Out_Sync = Out_Valid & accepted==0; Out_Last = Out_Valid & accepted==len-1. Both high if len==1.
//  Latency: first Out_Valid RD_LAT+1 cycles after accepted start. Steady throughput 1 byte/cycle when In_Ready=1.
//  Wrap: base+len beyond top of RAM wraps to address 0; length 2**ADDR_W reads every location once.
//  Length > 2**ADDR_W is impossible by width; length 0 yields only a Done pulse, no bytes.
//  Simultaneous push and pop on the FIFO: both happen; count unchanged.
//  Async reset mid-transfer aborts immediately; no Done pulse; state and FIFO cleared.
//  Out_Rdaddr holds its last value when not issuing; read side-effect free.
// STRUCTURE
//  Shared package/header: ADDR_W/DATA_W defaults, FSM state encodings (IDLE, RUN, DRAIN, DONE).
//  Sub-module mdpx_rd_fifo: synchronous show-ahead register FIFO, depth/width parameters.
//  It provides push, pop, count, empty, and full signals.
//  Top level holds the FSM, the counters, the address generator and the in-flight shift register.
// TESTING
//  Base=0x000, Len=16, In_Ready=1 -> bytes from RAM[0..15] in order, 1/cycle.
//    Sync on byte 0, Last on byte 15, Done 1 cycle after.
//  Base=0x3FC, Len=8 -> reads 0x3FC..0x3FF then 0x000..0x003; data matches; no gap.
//  Len=64 with In_Ready random 50% -> no loss or duplicate.
//    Out_Data stable while stalled; issue stops when credit exhausted.
//  Len=0 -> no Out_Valid; Out_Done pulse 1 cycle after start; Busy stays 0.
//    Len=1 -> single byte with Sync=Last=1.
//  Start pulse during a Len=32 transfer -> ignored; exactly 32 bytes, one Done.
//  Drop In_Nreset mid-transfer after 10 bytes -> outputs 0 at once; no Done.
//    A new Len=4 start after release -> correct 4 bytes.

Source files
------------

// File: rtl/mdpx_buf_reader_pkg.sv
// Shared defaults and FSM encoding for the
// frame-buffer read engine.
package mdpx_buf_reader_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/mdpx_rd_fifo.sv
// Show-ahead register FIFO used to absorb
// RAM read latency in the read engine.
module mdpx_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mdpx_buf_reader.sv
// Read engine: streams a byte range out of the
// frame-buffer RAM as a valid/ready stream.
module mdpx_buf_reader
  import mdpx_buf_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              In_Clk,
  input  logic              In_Nreset,
  input  logic              In_Start,
  input  logic [ADDR_W-1:0] In_Base_Addr,
  input  logic [ADDR_W:0]   In_Length,
  output logic [ADDR_W-1:0] Out_Rdaddr,
  input  logic [DATA_W-1:0] In_Rddata,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              In_Ready,
  output logic              Out_Sync,
  output logic              Out_Last,
  output logic              Out_Busy,
  output logic              Out_Done
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int LW = ADDR_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state, nxt;
  logic [ADDR_W-1:0] base_r;
  logic [LW-1:0]     len_r;
  logic [LW-1:0]     issued;
  logic [LW-1:0]     accepted;
  logic              iss_v;
  logic [RD_LAT-1:0] sh;
  logic [CW-1:0]     fifo_count;
  logic              empty;
  logic              full;
  logic              pop;
  logic              start_ok;
  logic              issue_run;
  logic              credit;
  logic              at_last;
  logic              last_pop;
  int                occ;

  mdpx_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CW    (CW)
  ) u_fifo (
    .clk   (In_Clk),
    .rst_n (In_Nreset),
    .push  (sh[RD_LAT-1]),
    .din   (In_Rddata),
    .pop   (pop),
    .dout  (Out_Data),
    .count (fifo_count),
    .empty (empty),
    .full  (full)
  );

  assign Out_Valid = !empty;
  assign pop       = Out_Valid && In_Ready;
  assign at_last   = (accepted == len_r - LW'(1));
  assign last_pop  = pop && at_last;
  assign Out_Sync  = Out_Valid && (accepted == '0);
  assign Out_Last  = Out_Valid && at_last;
  assign start_ok  = (state == S_IDLE) && In_Start;

  // A pop this cycle frees a slot, keeping 1 byte/cycle.
  always_comb begin
    occ = int'(fifo_count) + int'(iss_v) - int'(pop);
    for (int i = 0; i < RD_LAT; i++)
      occ = occ + int'(sh[i]);
    credit = (occ < FIFO_DEPTH) && !(full && !pop);
  end

  assign issue_run = (state == S_RUN)
                  && (issued < len_r) && credit;

  always_ff @(posedge In_Clk or negedge In_Nreset) begin
    if (!In_Nreset) state <= S_IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (In_Start)
          nxt = (In_Length == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (last_pop)             nxt = S_DONE;
        else if (issued == len_r) nxt = S_DRAIN;
      S_DRAIN:
        if (last_pop) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Out_Busy = 1'b0;
    Out_Done = 1'b0;
    unique case (1'b1)
      (state == S_RUN),
      (state == S_DRAIN): Out_Busy = 1'b1;
      (state == S_DONE):  Out_Done = 1'b1;
      default: ;
    endcase
  end

  // The start edge already issues the base address.
  always_ff @(posedge In_Clk or negedge In_Nreset) begin
    if (!In_Nreset) begin
      base_r     <= '0;
      len_r      <= '0;
      issued     <= '0;
      accepted   <= '0;
      Out_Rdaddr <= '0;
      iss_v      <= 1'b0;
      sh         <= '0;
    end else begin
      iss_v <= issue_run || (start_ok && In_Length != '0);
      sh[0] <= iss_v;
      for (int i = 1; i < RD_LAT; i++)
        sh[i] <= sh[i-1];
      if (start_ok) begin
        base_r   <= In_Base_Addr;
        len_r    <= In_Length;
        accepted <= '0;
        if (In_Length != '0) begin
          issued     <= LW'(1);
          Out_Rdaddr <= In_Base_Addr;
        end else begin
          issued <= '0;
        end
      end else begin
        if (issue_run) begin
          Out_Rdaddr <= base_r + issued[ADDR_W-1:0];
          issued     <= issued + LW'(1);
        end
        if (pop)
          accepted <= accepted + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mdpx_buf_reader.sv
// Scoreboard bench for mdpx_buf_reader with a
// 2-cycle-latency RAM model.
module tb_mdpx_buf_reader;

  typedef struct {
    logic [7:0] data;
    logic       sync;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base = '0;
  logic [10:0] len = '0;
  logic [9:0]  rdaddr;
  logic [7:0]  rddata;
  logic [7:0]  data;
  logic        valid;
  logic        ready = 1'b1;
  logic        sync;
  logic        last;
  logic        busy;
  logic        done;

  logic [7:0]  ram [1024];
  logic [7:0]  q0 = '0;
  logic [7:0]  q1 = '0;

  exp_t        exp_q[$];
  int          vec = 0;
  int          miss = 0;
  int          done_cnt = 0;
  int          pop_cnt = 0;
  bit          rnd = 0;
  bit          want_done = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;

  always #5 clk = ~clk;

  mdpx_buf_reader dut (
    .In_Clk       (clk),
    .In_Nreset    (rst_n),
    .In_Start     (start),
    .In_Base_Addr (base),
    .In_Length    (len),
    .Out_Rdaddr   (rdaddr),
    .In_Rddata    (rddata),
    .Out_Data     (data),
    .Out_Valid    (valid),
    .In_Ready     (ready),
    .Out_Sync     (sync),
    .Out_Last     (last),
    .Out_Busy     (busy),
    .Out_Done     (done)
  );

  always @(posedge clk) begin
    q0 <= ram[rdaddr];
    q1 <= q0;
  end
  assign rddata = q1;

  initial begin
    for (int i = 0; i < 1024; i++)
      ram[i] = 8'((i * 37) + (i >> 3) + 5);
  end

  initial forever begin
    @(posedge clk);
    #1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      want_done  = 0;
    end else begin
      if (want_done) begin
        vec++;
        if (done !== 1'b1) begin
          miss++;
          $display("FAIL done_after_last got=%b want=1", done);
        end
        want_done = 0;
      end
      if (done) done_cnt++;
      if (prev_stall) begin
        vec++;
        if (valid !== 1'b1 || data !== prev_data) begin
          miss++;
          $display("FAIL stall_hold got v=%b d=%h want v=1 d=%h",
                   valid, data, prev_data);
        end
      end
      if (valid && ready) begin
        vec++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL extra_byte got d=%h want none", data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (data !== e.data || sync !== e.sync || last !== e.last) begin
            miss++;
            $display("FAIL byte got d=%h s=%b l=%b want d=%h s=%b l=%b",
                     data, sync, last, e.data, e.sync, e.last);
          end
          if (e.last) want_done = 1;
        end
        pop_cnt++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic start_xfer(input logic [9:0] b, input logic [10:0] l,
                            input bit push_exp);
    @(posedge clk);
    #1;
    base  = b;
    len   = l;
    start = 1'b1;
    if (push_exp)
      for (int i = 0; i < int'(l); i++) begin
        exp_t e;
        e.data = ram[10'(int'(b) + i)];
        e.sync = (i == 0);
        e.last = (i == int'(l) - 1);
        exp_q.push_back(e);
      end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(target));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int p0;
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {rdaddr, data, valid, sync, last, busy, done}, '0);
    #1 rst_n = 1'b1;

    // aligned 16-byte read with latency check
    start_xfer(10'h000, 11'd16, 1);
    repeat (3) @(negedge clk);
    check("lat_not_yet", {busy, valid}, 2'b10);
    @(negedge clk);
    check("lat_first", {busy, valid}, 2'b11);
    wait_done(1);

    // wrap past top of RAM
    start_xfer(10'h3FC, 11'd8, 1);
    wait_done(2);

    // random backpressure
    rnd = 1;
    start_xfer(10'h123, 11'd64, 1);
    wait_done(3);
    rnd = 0;

    // zero-length: only a Done pulse
    start_xfer(10'h040, 11'd0, 1);
    @(negedge clk);
    check("len0_pulse", {done, busy, valid}, 3'b100);
    @(negedge clk);
    check("len0_after", {done, busy, valid}, 3'b000);
    check("len0_done_cnt", 32'(done_cnt), 32'd4);

    // single byte: sync and last together
    start_xfer(10'h3FF, 11'd1, 1);
    wait_done(5);

    // start during a transfer is ignored
    start_xfer(10'h100, 11'd32, 1);
    repeat (5) @(posedge clk);
    start_xfer(10'h050, 11'd7, 0);
    wait_done(6);
    repeat (20) @(negedge clk);
    check("ignored_start", {32'(done_cnt), 31'd0, valid}, {32'd6, 32'd0});

    // full-buffer read
    start_xfer(10'h200, 11'd1024, 1);
    wait_done(7);

    // async reset mid-transfer
    p0 = pop_cnt;
    start_xfer(10'h010, 11'd40, 1);
    t = 0;
    while (pop_cnt < p0 + 10 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ten_bytes", 32'(pop_cnt >= p0 + 10), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {rdaddr, data, valid, sync, last, busy, done}, '0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    start_xfer(10'h3FE, 11'd4, 1);
    wait_done(d0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
